// File: rtl/decode_queue_stage_if.sv
// decode_queue_stage_if: fetch-side and execute-side handshake bundle.
// slave = decode stage view, master = fetch/execute/test view.
interface decode_queue_stage_if #(
  parameter int N_BITS = 32,
  parameter int DEPTH  = 4
);
  logic              in_vld;
  logic              in_rdy;
  logic [N_BITS-1:0] in_instr;
  logic [N_BITS-1:0] in_pc;
  logic              squash;
  logic              out_vld;
  logic              out_rdy;
  logic [N_BITS-1:0] out_pc;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [4:0]        out_rd;
  logic [N_BITS-1:0] out_imm;
  logic [3:0]        out_alu_op;
  logic              out_wr_en;
  logic              out_is_load;
  logic              out_is_store;
  logic              out_is_branch;
  logic              out_is_jalr;
  logic              jal_redirect;
  logic [N_BITS-1:0] jal_tgt;
  logic [$clog2(DEPTH):0] occupancy;

  modport slave (
    input  in_vld, in_instr, in_pc,
    input  squash, out_rdy,
    output in_rdy, out_vld, out_pc,
    output out_rs1, out_rs2, out_rd,
    output out_imm, out_alu_op,
    output out_wr_en, out_is_load,
    output out_is_store, out_is_branch,
    output out_is_jalr, jal_redirect,
    output jal_tgt, occupancy
  );

  modport master (
    output in_vld, in_instr, in_pc,
    output squash, out_rdy,
    input  in_rdy, out_vld, out_pc,
    input  out_rs1, out_rs2, out_rd,
    input  out_imm, out_alu_op,
    input  out_wr_en, out_is_load,
    input  out_is_store, out_is_branch,
    input  out_is_jalr, jal_redirect,
    input  jal_tgt, occupancy
  );
endinterface

// File: rtl/decode_queue_stage.sv
// decode_queue_stage: RV32I instruction queue + head decode + load scoreboard.
// Ports: clk, rst (sync, active high), io (decode_queue_stage_if.slave).
module decode_queue_stage #(
  parameter int N_BITS   = 32,
  parameter int DEPTH    = 4,
  parameter int LOAD_LAT = 2
) (
  input logic clk,
  input logic rst,
  decode_queue_stage_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LOAD_LAT + 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [N_BITS-1:0] instr_q [DEPTH];
  logic [N_BITS-1:0] pc_q    [DEPTH];
  logic [AW:0]       count;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     sb_cnt  [32];

  logic [N_BITS-1:0] h;
  logic [N_BITS-1:0] h_pc;
  logic [6:0]        op;
  logic [2:0]        f3;
  logic              head_present;
  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_ld, is_st, is_ri, is_rr;
  logic rs1_vld, rs2_vld, wr_en;
  logic [N_BITS-1:0] imm;
  logic [N_BITS-1:0] imm_i, imm_s, imm_b;
  logic [N_BITS-1:0] imm_u, imm_j;
  logic [3:0]        alu_op;
  logic stall, vld, issue, enq, jal_go, flush;

  assign h            = instr_q[rd_ptr];
  assign h_pc         = pc_q[rd_ptr];
  assign op           = h[6:0];
  assign f3           = h[14:12];
  assign head_present = (count != '0);

  assign is_lui   = (op == 7'b0110111);
  assign is_auipc = (op == 7'b0010111);
  assign is_jal   = (op == 7'b1101111);
  assign is_jalr  = (op == 7'b1100111);
  assign is_br    = (op == 7'b1100011);
  assign is_ld    = (op == 7'b0000011);
  assign is_st    = (op == 7'b0100011);
  assign is_ri    = (op == 7'b0010011);
  assign is_rr    = (op == 7'b0110011);

  assign imm_i = {{21{h[31]}}, h[30:20]};
  assign imm_s = {{21{h[31]}}, h[30:25], h[11:7]};
  assign imm_b = {{20{h[31]}}, h[7], h[30:25],
                  h[11:8], 1'b0};
  assign imm_u = {h[31:12], 12'b0};
  assign imm_j = {{12{h[31]}}, h[19:12], h[20],
                  h[30:21], 1'b0};

  always_comb begin
    imm     = '0;
    rs1_vld = 1'b0;
    rs2_vld = 1'b0;
    wr_en   = 1'b0;
    unique case (1'b1)
      is_lui, is_auipc: begin
        imm   = imm_u;
        wr_en = 1'b1;
      end
      is_jal: begin
        imm   = imm_j;
        wr_en = 1'b1;
      end
      is_jalr, is_ld, is_ri: begin
        imm     = imm_i;
        rs1_vld = 1'b1;
        wr_en   = 1'b1;
      end
      is_br: begin
        imm     = imm_b;
        rs1_vld = 1'b1;
        rs2_vld = 1'b1;
      end
      is_st: begin
        imm     = imm_s;
        rs1_vld = 1'b1;
        rs2_vld = 1'b1;
      end
      is_rr: begin
        rs1_vld = 1'b1;
        rs2_vld = 1'b1;
        wr_en   = 1'b1;
      end
      default: ;
    endcase
  end

  // addi has no subtract form, so bit 30 is an immediate bit there
  always_comb begin
    alu_op = '0;
    if (is_rr)
      alu_op = {h[30], f3};
    else if (is_ri)
      alu_op = {(f3 == 3'b000) ? 1'b0 : h[30], f3};
  end

  assign stall = (rs1_vld && sb_cnt[h[19:15]] != '0) ||
                 (rs2_vld && sb_cnt[h[24:20]] != '0);
  assign vld    = !rst && head_present && !stall &&
                  !io.squash;
  assign issue  = vld && io.out_rdy;
  assign jal_go = issue && is_jal;
  assign flush  = io.squash || jal_go;
  assign enq    = io.in_vld && io.in_rdy && !flush;

  assign io.in_rdy        = !rst && (count < FULL);
  assign io.out_vld       = vld;
  assign io.out_pc        = h_pc;
  assign io.out_rs1       = h[19:15];
  assign io.out_rs2       = h[24:20];
  assign io.out_rd        = h[11:7];
  assign io.out_imm       = imm;
  assign io.out_alu_op    = alu_op;
  assign io.out_wr_en     = wr_en;
  assign io.out_is_load   = is_ld;
  assign io.out_is_store  = is_st;
  assign io.out_is_branch = is_br;
  assign io.out_is_jalr   = is_jalr;
  assign io.jal_redirect  = jal_go;
  assign io.jal_tgt       = h_pc + imm_j;
  assign io.occupancy     = count;

  always_ff @(posedge clk) begin
    if (enq) begin
      instr_q[wr_ptr] <= io.in_instr;
      pc_q[wr_ptr]    <= io.in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int r = 0; r < 32; r++)
        sb_cnt[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (issue && is_ld && h[11:7] == 5'(r))
          sb_cnt[r] <= CW'(LOAD_LAT);
        else if (sb_cnt[r] != '0)
          sb_cnt[r] <= sb_cnt[r] - 1'b1;
      end
      // loads already issued are older, so the
      // scoreboard survives a flush
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (enq)
          wr_ptr <= wr_ptr + 1'b1;
        if (issue)
          rd_ptr <= rd_ptr + 1'b1;
        if (enq && !issue)
          count <= count + 1'b1;
        else if (!enq && issue)
          count <= count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_decode_queue_stage.sv
// tb_decode_queue_stage: vector table, directed corners, random vs model.
// Drives io as master; model is a queue plus per-register busy cycles.
module tb_decode_queue_stage;
  localparam int N_BITS   = 32;
  localparam int DEPTH    = 4;
  localparam int LOAD_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_queue_stage_if #(.N_BITS(N_BITS), .DEPTH(DEPTH)) io ();

  decode_queue_stage #(
    .N_BITS(N_BITS), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .io(io.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];
  int   busy[32];

  typedef struct {
    logic [31:0] imm;
    logic [3:0]  alu;
    logic wr, ld, st, br, jalr, jal, r1v, r2v;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    d = '{default: '0};
    case (i[6:0])
      7'h37, 7'h17: begin
        d.imm = {i[31:12], 12'h000}; d.wr = 1;
      end
      7'h6f: begin
        d.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        d.wr = 1; d.jal = 1;
      end
      7'h67, 7'h03, 7'h13: begin
        d.imm = {{21{i[31]}}, i[30:20]};
        d.r1v = 1; d.wr = 1;
        d.jalr = (i[6:0] == 7'h67);
        d.ld   = (i[6:0] == 7'h03);
        if (i[6:0] == 7'h13)
          d.alu = {(i[14:12] == 3'd0) ? 1'b0 : i[30], i[14:12]};
      end
      7'h63: begin
        d.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        d.r1v = 1; d.r2v = 1; d.br = 1;
      end
      7'h23: begin
        d.imm = {{21{i[31]}}, i[30:25], i[11:7]};
        d.r1v = 1; d.r2v = 1; d.st = 1;
      end
      7'h33: begin
        d.r1v = 1; d.r2v = 1; d.wr = 1;
        d.alu = {i[30], i[14:12]};
      end
      default: ;
    endcase
    return d;
  endfunction

  task automatic cyc(input logic r, input logic iv,
                     input logic [31:0] ins,
                     input logic [31:0] pc,
                     input logic sq, input logic ordy);
    logic hp, stall, e_ovld, e_irdy, issue, enq, e_jal;
    logic [31:0] hi, hpc;
    dec_t d;
    rst = r;
    io.in_vld = iv; io.in_instr = ins; io.in_pc = pc;
    io.squash = sq; io.out_rdy = ordy;
    #1;
    hp  = (mq.size() > 0);
    hi  = hp ? mq[0].instr : 32'h0;
    hpc = hp ? mq[0].pc : 32'h0;
    d   = decode(hi);
    stall = (d.r1v && busy[hi[19:15]] > 0) ||
            (d.r2v && busy[hi[24:20]] > 0);
    e_ovld = !r && hp && !stall && !sq;
    e_irdy = !r && (mq.size() < DEPTH);
    issue  = e_ovld && ordy;
    enq    = iv && e_irdy;
    e_jal  = issue && d.jal;
    chk("in_rdy", 32'(io.in_rdy), 32'(e_irdy));
    chk("out_vld", 32'(io.out_vld), 32'(e_ovld));
    chk("occupancy", 32'(io.occupancy), 32'(mq.size()));
    chk("jal_redirect", 32'(io.jal_redirect), 32'(e_jal));
    if (hp) begin
      chk("out_pc", io.out_pc, hpc);
      chk("out_rs1", 32'(io.out_rs1), 32'(hi[19:15]));
      chk("out_rs2", 32'(io.out_rs2), 32'(hi[24:20]));
      chk("out_rd", 32'(io.out_rd), 32'(hi[11:7]));
      chk("out_imm", io.out_imm, d.imm);
      chk("out_alu_op", 32'(io.out_alu_op), 32'(d.alu));
      chk("flags", {27'd0, io.out_wr_en, io.out_is_load,
                    io.out_is_store, io.out_is_branch,
                    io.out_is_jalr},
                   {27'd0, d.wr, d.ld, d.st, d.br, d.jalr});
    end
    if (e_jal)
      chk("jal_tgt", io.jal_tgt, hpc + d.imm);
    @(posedge clk);
    if (r) begin
      mq.delete();
      foreach (busy[k]) busy[k] = 0;
    end else begin
      for (int k = 1; k < 32; k++) begin
        if (issue && d.ld && hi[11:7] == 5'(k))
          busy[k] = LOAD_LAT;
        else if (busy[k] > 0)
          busy[k]--;
      end
      if (sq || e_jal) mq.delete();
      else begin
        if (issue) void'(mq.pop_front());
        if (enq) mq.push_back('{ins, pc});
      end
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, ordy);
  endtask

  task automatic push(input logic [31:0] ins,
                      input logic [31:0] pc,
                      input logic ordy);
    cyc(1'b0, 1'b1, ins, pc, 1'b0, ordy);
  endtask

  function automatic logic [31:0] addi(input int k);
    return {12'(k), 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [4:0]  flags;
  } vec_t;

  vec_t vt[8];
  localparam logic [6:0] OPS [9] = '{7'h37, 7'h17, 7'h6f, 7'h67,
                                     7'h63, 7'h03, 7'h23, 7'h13,
                                     7'h33};

  initial begin
    logic [31:0] r32, ins;
    rst = 1'b1;
    io.in_vld = 0; io.in_instr = 0; io.in_pc = 0;
    io.squash = 0; io.out_rdy = 0;
    foreach (busy[k]) busy[k] = 0;
    @(posedge clk); #1;
    cyc(1'b1, 1'b1, addi(1), 32'h0, 1'b0, 1'b1);
    idle(1'b0);
    chk("rst_release_rdy", 32'(io.in_rdy), 32'd1);

    // flags = {wr, ld, st, br, jalr}
    vt[0] = '{32'hFFF00093, 32'hFFFFFFFF, 4'b0000, 5'b10000};
    vt[1] = '{32'h40208033, 32'h00000000, 4'b1000, 5'b10000};
    vt[2] = '{32'h123450B7, 32'h12345000, 4'b0000, 5'b10000};
    vt[3] = '{32'h0020A423, 32'h00000008, 4'b0000, 5'b00100};
    vt[4] = '{32'hFE208EE3, 32'hFFFFFFFC, 4'b0000, 5'b00010};
    vt[5] = '{32'h4030D093, 32'h00000403, 4'b1101, 5'b10000};
    vt[6] = '{32'h008000EF, 32'h00000008, 4'b0000, 5'b10000};
    vt[7] = '{32'h0000A183, 32'h00000000, 4'b0000, 5'b11000};
    for (int v = 0; v < 8; v++) begin
      push(vt[v].instr, 32'h40 + 32'(v * 4), 1'b0);
      chk("tbl_vld", 32'(io.out_vld), 32'd1);
      chk("tbl_imm", io.out_imm, vt[v].imm);
      chk("tbl_alu", 32'(io.out_alu_op), 32'(vt[v].alu));
      chk("tbl_flags", {27'd0, io.out_wr_en, io.out_is_load,
                        io.out_is_store, io.out_is_branch,
                        io.out_is_jalr}, 32'(vt[v].flags));
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end

    for (int k = 0; k < 4; k++)
      push(addi(k), 32'h200 + 32'(k * 4), 1'b0);
    chk("fill_occ", 32'(io.occupancy), 32'd4);
    chk("fill_rdy", 32'(io.in_rdy), 32'd0);
    push(addi(9), 32'h210, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc", io.out_pc, 32'h200 + 32'(k * 4));
      idle(1'b1);
    end
    chk("drain_occ", 32'(io.occupancy), 32'd0);

    push({12'd0, 5'd1, 3'b010, 5'd5, 7'h03}, 32'h300, 1'b1);
    push({7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'h33}, 32'h304, 1'b1);
    chk("lu_stall1", 32'(io.out_vld), 32'd0);
    idle(1'b1);
    chk("lu_stall2", 32'(io.out_vld), 32'd0);
    idle(1'b1);
    chk("lu_go", 32'(io.out_vld), 32'd1);
    idle(1'b1);
    push({12'd0, 5'd1, 3'b010, 5'd0, 7'h03}, 32'h308, 1'b1);
    push({7'd0, 5'd1, 5'd0, 3'd0, 5'd6, 7'h33}, 32'h30c, 1'b1);
    chk("x0_nostall", 32'(io.out_vld), 32'd1);
    idle(1'b1);

    push(32'h008000EF, 32'h100, 1'b0);
    push(addi(1), 32'h104, 1'b0);
    push(addi(2), 32'h108, 1'b0);
    io.in_vld = 1; io.in_instr = addi(3); io.in_pc = 32'h10c;
    io.out_rdy = 1; #1;
    chk("jal_redir", 32'(io.jal_redirect), 32'd1);
    chk("jal_tgt_c", io.jal_tgt, 32'h108);
    cyc(1'b0, 1'b1, addi(3), 32'h10c, 1'b0, 1'b1);
    chk("jal_flush_occ", 32'(io.occupancy), 32'd0);

    push({12'd0, 5'd1, 3'b010, 5'd7, 7'h03}, 32'h400, 1'b0);
    push(addi(1), 32'h404, 1'b0);
    push({7'd0, 5'd0, 5'd7, 3'd0, 5'd9, 7'h33}, 32'h408, 1'b0);
    push(addi(2), 32'h40c, 1'b1);
    io.squash = 1; io.in_vld = 1; #1;
    chk("sq_vld", 32'(io.out_vld), 32'd0);
    cyc(1'b0, 1'b1, addi(4), 32'h410, 1'b1, 1'b1);
    chk("sq_occ", 32'(io.occupancy), 32'd0);
    chk("sq_sb_kept", 32'(dut.sb_cnt[7]), 32'd1);
    idle(1'b1);

    push({12'd0, 5'd1, 3'b010, 5'd3, 7'h03}, 32'h500, 1'b0);
    for (int k = 0; k < 3; k++)
      push(addi(k), 32'h504 + 32'(k * 4), 1'b0);
    idle(1'b1);
    push(addi(7), 32'h510, 1'b0);
    cyc(1'b1, 1'b1, addi(8), 32'h514, 1'b0, 1'b1);
    chk("rst_occ", 32'(io.occupancy), 32'd0);
    chk("rst_sb", 32'(dut.sb_cnt[3]), 32'd0);
    idle(1'b0);
    chk("rst_rdy", 32'(io.in_rdy), 32'd1);

    for (int c = 0; c < 3000; c++) begin
      r32 = $urandom();
      ins = r32;
      ins[6:0]   = OPS[$urandom_range(0, 8)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 9) < 7, ins,
          {$urandom_range(0, 1023), 2'b00},
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 9) < 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
